reg_file_mp: RTL
================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port register file for the single-cycle datapath; successor to the fixed 32x32 2R1W file.
//  Adds configurable width/depth, N read ports, 2 write ports with fixed priority, optional hardwired zero register,
//  and a sequenced bulk-clear engine with a busy flag. Sits between decode (addresses) and ALU/writeback (data).
// PARAMETERS
//  DW        32  data width in bits
//  DEPTH     32  number of registers (power of 2, >=2); AW = $clog2(DEPTH)
//  NRD       2   number of read ports
//  ZERO_REG  1   1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary storage
// PORTS
//  i_clk    in   1        clock, rising edge
//  i_rst_n  in   1        reset, asynchronous, active-low
//  i_raddr  in   NRD*AW   read addresses, port r at [r*AW +: AW]
//  o_rdata  out  NRD*DW   read data, port r at [r*DW +: DW]
//  i_we     in   2        write enable per write port
//  i_waddr  in   2*AW     write addresses, port w at [w*AW +: AW]
//  i_wdata  in   2*DW     write data, port w at [w*DW +: DW]
//  i_clr    in   1        single-cycle pulse: start bulk clear
//  o_busy   out  1        registered; 1 while clear sweep in progress
// BEHAVIOUR
//  - Reset (i_rst_n=0, async): every register 0, FSM IDLE, sweep index 0, o_busy 0; o_rdata reflects zeros.
//  - Read: combinational from array, zero cycle latency; ZERO_REG=1 and address 0 -> 0 on that port.
//  - Write: on rising edge when i_we[w]=1 and FSM IDLE; latency 1 cycle to visibility (see macro).
//  - Same-address double write: port 1 wins; port 0 data discarded.
//  - ZERO_REG=1: writes to address 0 dropped silently on both ports.
//  - FSM IDLE: i_clr=1 -> CLEAR, index<=0, o_busy<=1 on same edge; writes that cycle still performed.
//  - FSM CLEAR: each edge zeroes reg[index], index++; all i_we ignored; i_clr ignored; reads return current contents
//    (mix of cleared/uncleared). At index=DEPTH-1: zero it, -> IDLE, o_busy<=0. o_busy high exactly DEPTH cycles.
//  - Reset mid-sweep: immediate return to IDLE with all registers 0, o_busy 0.
//  - Index wraps never; it is AW bits and terminates at DEPTH-1.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: a read address matching an enabled, accepted write in the same cycle returns that
//    write data combinationally (port 1 priority; not for addr 0 when ZERO_REG=1; not during CLEAR).
//  REGFILE_BYPASS_EN undefined: read returns stored value; new data visible the cycle after the write edge.
// STRUCTURE
//  - Package reg_file_pkg: clear-FSM state enum (ST_IDLE, ST_CLEAR), write-port count constant NWR=2.
//  - Sub-module reg_file_clr_fsm: owns state, sweep index, o_busy; outputs clear-enable and clear-index to array.
//  - Top: storage array, write-priority/enable logic, read muxes, optional bypass.
// TESTING  (DW=32, DEPTH=32, NRD=2, ZERO_REG=1)
//  1. Pulse i_rst_n low after random writes -> all 32 addresses read 0 on both ports, o_busy=0.
//  2. Write 5 to addr 3 on port 0; read addr 3 same cycle -> 5 with bypass, 0 without; next cycle -> 5 either way.
//  3. Same edge: port0 writes 0xAAAA_AAAA, port1 writes 0x5555_5555, both addr 7 -> addr 7 reads 0x5555_5555.
//  4. Write 0xDEAD_BEEF to addr 0 -> addr 0 reads 0; ZERO_REG=0 rerun -> reads 0xDEAD_BEEF.
//  5. Fill addr 1..31 with addr*5, pulse i_clr -> o_busy high 32 cycles; write 9 to addr 4 at cycle 10 dropped;
//     second i_clr at cycle 12 ignored; after o_busy falls all reads 0.
//  6. i_rst_n low at sweep index 10 -> o_busy 0 immediately, all regs 0, new i_clr restarts full 32-cycle sweep.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and constants for the multi-port register file
package reg_file_pkg;
    localparam int NWR = 2;
    typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;
endpackage

// File: rtl/reg_file_clr_fsm.sv
// reg_file_clr_fsm: sequences a one-register-per-cycle bulk clear and reports busy
module reg_file_clr_fsm
    import reg_file_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_idx
);
    clr_state_t    state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic          busy_nxt;
    logic          last;

    assign last    = idx == AW'(DEPTH - 1);
    assign clr_en  = state == ST_CLEAR;
    assign clr_idx = idx;

    // state, sweep index and busy flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            busy  <= busy_nxt;
        end
    end

    // start on a clear pulse while idle; in a sweep advance until the last register
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        busy_nxt  = busy;
        if (state == ST_IDLE && clr) begin
            state_nxt = ST_CLEAR;
            idx_nxt   = '0;
            busy_nxt  = 1'b1;
        end else if (state == ST_CLEAR) begin
            state_nxt = last ? ST_IDLE : ST_CLEAR;
            idx_nxt   = last ? '0 : idx + 1'b1;
            busy_nxt  = !last;
        end
    end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised NRD-read / 2-write register file with bulk clear; REGFILE_BYPASS_EN enables write-to-read bypass
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NRD*$clog2(DEPTH)-1:0] i_raddr,
    output logic [NRD*DW-1:0]           o_rdata,
    input  logic [NWR-1:0]              i_we,
    input  logic [NWR*$clog2(DEPTH)-1:0] i_waddr,
    input  logic [NWR*DW-1:0]           i_wdata,
    input  logic                        i_clr,
    output logic                        o_busy
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0]  mem [DEPTH];
    logic           clr_en;
    logic [AW-1:0]  clr_idx;
    logic [NWR-1:0] we_ok;

    reg_file_clr_fsm #(.DEPTH(DEPTH), .AW(AW)) u_clr (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clr     (i_clr),
        .busy    (o_busy),
        .clr_en  (clr_en),
        .clr_idx (clr_idx)
    );

    function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d = mem[a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NWR; w++)
            if (we_ok[w] && i_waddr[w*AW +: AW] == a) d = i_wdata[w*DW +: DW];
`endif
        return (ZERO_REG != 0 && a == '0) ? '0 : d;
    endfunction

    // a write is accepted only outside a sweep and never to the hardwired zero register
    always_comb begin
        we_ok = '0;
        for (int w = 0; w < NWR; w++)
            we_ok[w] = i_we[w] && !clr_en && !(ZERO_REG != 0 && i_waddr[w*AW +: AW] == '0);
    end

    // storage: sweep clear has precedence; port 1 is applied last so it wins on equal addresses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr_en) begin
            mem[clr_idx] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++)
                if (we_ok[w]) mem[i_waddr[w*AW +: AW]] <= i_wdata[w*DW +: DW];
        end
    end

    // combinational read muxes, one per read port
    always_comb begin
        o_rdata = '0;
        for (int r = 0; r < NRD; r++) o_rdata[r*DW +: DW] = rd_port(i_raddr[r*AW +: AW]);
    end
endmodule
